// File: rtl/noc_pkg.sv
// Shared mesh-NoC definitions: output port indices, route FSM state type and
// the beat-0 header field extractor used by the route decoder.
// No ports (package).
package noc_pkg;

  // Output port indices of a mesh router
  localparam int PORT_N  = 0;
  localparam int PORT_E  = 1;
  localparam int PORT_S  = 2;
  localparam int PORT_W  = 3;
  localparam int PORT_L0 = 4;

  // Header fields are 8 bits wide; the field offsets are spaced 8 bits apart
  // by default. Keeping the field wider than the coordinate lets an
  // out-of-mesh target (e.g. X=5 in a 4-column mesh) be recognised.
  localparam int HDR_FIELD_W = 8;
  localparam int HDR_MAX_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FORWARD,
    ST_DROP
  } route_state_e;

  typedef struct packed {
    logic [HDR_FIELD_W-1:0] x;
    logic [HDR_FIELD_W-1:0] y;
    logic [HDR_FIELD_W-1:0] l;
  } hdr_xy_t;

  function automatic hdr_xy_t hdr_xy_decode(input logic [HDR_MAX_W-1:0] data,
                                            input int unsigned x_lsb,
                                            input int unsigned y_lsb,
                                            input int unsigned l_lsb);
    hdr_xy_t h;
    logic [HDR_MAX_W-1:0] sx, sy, sl;
    sx  = data >> x_lsb;
    sy  = data >> y_lsb;
    sl  = data >> l_lsb;
    h.x = sx[HDR_FIELD_W-1:0];
    h.y = sy[HDR_FIELD_W-1:0];
    h.l = sl[HDR_FIELD_W-1:0];
    return h;
  endfunction

endpackage

// File: rtl/xy_route_decode.sv
// Combinational header -> output port / drop decision for one router input.
// Optional macro ROUTER_ADAPTIVE_EN: minimal-adaptive choice between the
// productive X and Y directions based on downstream ready; otherwise strict XY.
// Ports:
//   hdr   in  DATA_WIDTH      beat-0 TDATA
//   ready in  CHANNEL_NUMBER  downstream TREADY (used only in adaptive mode)
//   port  out PORT_IDX_W      selected output
//   drop  out 1               target outside the mesh / nonexistent local port
module xy_route_decode
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int LOCAL_PORTS   = 1,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0,
  parameter int X_LSB         = 0,
  parameter int Y_LSB         = 8,
  parameter int L_LSB         = 16,
  localparam int CHANNEL_NUMBER = 4 + LOCAL_PORTS,
  localparam int PORT_IDX_W     = $clog2(CHANNEL_NUMBER)
) (
  input  logic [DATA_WIDTH-1:0]     hdr,
  input  logic [CHANNEL_NUMBER-1:0] ready,
  output logic [PORT_IDX_W-1:0]     port,
  output logic                      drop
);

  localparam logic [HDR_FIELD_W-1:0] MAX_X = HDR_FIELD_W'(MAX_ROUTERS_X);
  localparam logic [HDR_FIELD_W-1:0] MAX_Y = HDR_FIELD_W'(MAX_ROUTERS_Y);
  localparam logic [HDR_FIELD_W-1:0] OWN_X = HDR_FIELD_W'(ROUTER_X);
  localparam logic [HDR_FIELD_W-1:0] OWN_Y = HDR_FIELD_W'(ROUTER_Y);
  localparam logic [HDR_FIELD_W-1:0] NUM_L = HDR_FIELD_W'(LOCAL_PORTS);

  logic [HDR_MAX_W-1:0]  hdr_ext;
  hdr_xy_t               h;
  logic                  x_prod;
  logic                  y_prod;
  logic [PORT_IDX_W-1:0] x_port;
  logic [PORT_IDX_W-1:0] y_port;

  assign hdr_ext = HDR_MAX_W'(hdr);

  always_comb begin
    h      = hdr_xy_decode(hdr_ext, X_LSB, Y_LSB, L_LSB);
    drop   = 1'b0;
    port   = PORT_IDX_W'(PORT_L0) + PORT_IDX_W'(h.l);
    x_prod = (h.x != OWN_X);
    y_prod = (h.y != OWN_Y);
    x_port = (h.x > OWN_X) ? PORT_IDX_W'(PORT_E) : PORT_IDX_W'(PORT_W);
    y_port = (h.y > OWN_Y) ? PORT_IDX_W'(PORT_S) : PORT_IDX_W'(PORT_N);
    if (h.x >= MAX_X || h.y >= MAX_Y) begin
      drop = 1'b1;
    end else if (x_prod) begin
`ifdef ROUTER_ADAPTIVE_EN
      // X wins unless only the Y direction can accept right now
      if (y_prod && !ready[x_port] && ready[y_port]) port = y_port;
      else                                           port = x_port;
`else
      port = x_port;
`endif
    end else if (y_prod) begin
      port = y_port;
    end else if (h.l >= NUM_L) begin
      drop = 1'b1;
    end
  end

`ifdef ROUTER_ADAPTIVE_EN
`else
  // strict XY ignores downstream ready
  logic unused_ready;
  assign unused_ready = ^ready;
`endif

endmodule

// File: rtl/xy_route_lock.sv
// Packet-locking XY route controller for one mesh router input. Decodes the
// destination from beat 0, locks one output for the whole packet (until the
// TLAST handshake) and discards/counts packets addressed outside the mesh.
// Optional macro ROUTER_ADAPTIVE_EN selects minimal-adaptive routing in the
// decoder; default is strict XY.
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   in_tvalid/tready/tdata/tlast/tuser   input AXI-Stream
//   out_tvalid/tready/tdata/tlast/tuser  CHANNEL_NUMBER output streams
//                                 (0..3 = N,E,S,W; 4.. = local ports)
//   locked_port  currently held output
//   busy         high in FORWARD or DROP
//   drop_pulse   one-cycle pulse (first DROP cycle) per dropped packet
//   drop_count   saturating dropped-packet count
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | header seen on TVALID is decoded, not consumed (1 bubble)
// ST_FORWARD | in <-> out[locked_port] combinational path until TLAST
// ST_DROP    | in.TREADY held high, beats discarded until TLAST
module xy_route_lock
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int USER_WIDTH    = 1,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int LOCAL_PORTS   = 1,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0,
  parameter int X_LSB         = 0,
  parameter int Y_LSB         = 8,
  parameter int L_LSB         = 16,
  parameter int CNT_WIDTH     = 16,
  localparam int CHANNEL_NUMBER = 4 + LOCAL_PORTS,
  localparam int PORT_IDX_W     = $clog2(CHANNEL_NUMBER)
) (
  input  logic                                      ACLK,
  input  logic                                      ARESET,
  input  logic                                      in_tvalid,
  output logic                                      in_tready,
  input  logic [DATA_WIDTH-1:0]                     in_tdata,
  input  logic                                      in_tlast,
  input  logic [USER_WIDTH-1:0]                     in_tuser,
  output logic [CHANNEL_NUMBER-1:0]                 out_tvalid,
  input  logic [CHANNEL_NUMBER-1:0]                 out_tready,
  output logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0] out_tdata,
  output logic [CHANNEL_NUMBER-1:0]                 out_tlast,
  output logic [CHANNEL_NUMBER-1:0][USER_WIDTH-1:0] out_tuser,
  output logic [PORT_IDX_W-1:0]                     locked_port,
  output logic                                      busy,
  output logic                                      drop_pulse,
  output logic [CNT_WIDTH-1:0]                      drop_count
);

  route_state_e          state, state_nxt;
  logic [PORT_IDX_W-1:0] port_q;
  logic                  drop_pulse_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [PORT_IDX_W-1:0] dec_port;
  logic                  dec_drop;

  xy_route_decode #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_ROUTERS_X (MAX_ROUTERS_X),
    .MAX_ROUTERS_Y (MAX_ROUTERS_Y),
    .LOCAL_PORTS   (LOCAL_PORTS),
    .ROUTER_X      (ROUTER_X),
    .ROUTER_Y      (ROUTER_Y),
    .X_LSB         (X_LSB),
    .Y_LSB         (Y_LSB),
    .L_LSB         (L_LSB)
  ) u_decode (
    .hdr   (in_tdata),
    .ready (out_tready),
    .port  (dec_port),
    .drop  (dec_drop)
  );

  // Payload is broadcast; only TVALID selects the destination.
  assign out_tdata = {CHANNEL_NUMBER{in_tdata}};
  assign out_tlast = {CHANNEL_NUMBER{in_tlast}};
  assign out_tuser = {CHANNEL_NUMBER{in_tuser}};

  always_comb begin
    state_nxt  = state;
    in_tready  = 1'b0;
    out_tvalid = '0;
    case (state)
      ST_IDLE: begin
        if (in_tvalid) state_nxt = dec_drop ? ST_DROP : ST_FORWARD;
      end
      ST_FORWARD: begin
        in_tready          = out_tready[port_q];
        out_tvalid[port_q] = in_tvalid;
        if (in_tvalid && out_tready[port_q] && in_tlast) state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        in_tready = 1'b1;
        if (in_tvalid && in_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= ST_IDLE;
      port_q       <= '0;
      drop_pulse_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state        <= state_nxt;
      drop_pulse_q <= 1'b0;
      if (state == ST_IDLE && in_tvalid) begin
        if (dec_drop) begin
          drop_pulse_q <= 1'b1;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end else begin
          port_q <= dec_port;
        end
      end
    end
  end

  assign locked_port = port_q;
  assign busy        = (state != ST_IDLE);
  assign drop_pulse  = drop_pulse_q;
  assign drop_count  = cnt_q;

endmodule
